// File: rtl/vedic_pkg.sv
// Shared types and helpers for the iterative Vedic multiplier.
package vedic_pkg;

  localparam int unsigned MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  function automatic int unsigned col_w(input int unsigned width);
    return $clog2(2 * width) + 1;
  endfunction

endpackage

// File: rtl/vedic_mult_seq_column_sum.sv
// Crosswise AND-sum for one product column: popcount of a[i] & b[j] over i + j == col.
module vedic_column_sum
  import vedic_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  localparam int unsigned COL_W = col_w(WIDTH)
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [COL_W-1:0] col_i,
  output logic [COL_W-1:0] sum_o
);

  always_comb begin
    sum_o = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      for (int unsigned j = 0; j < WIDTH; j++) begin
        if (i + j == 32'(col_i)) begin
          sum_o = sum_o + COL_W'(a_i[i] & b_i[j]);
        end
      end
    end
  end

endmodule

// File: rtl/vedic_mult_seq.sv
// Iterative Urdhva-Tiryagbhyam multiplier, one product column per clock.
// Define VEDIC_MULT_SIGNED_EN to add the signed_i two's-complement mode.
module vedic_mult_seq
  import vedic_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  localparam int unsigned PROD_W = 2 * WIDTH,
  localparam int unsigned COL_W = col_w(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a_i,
  input  logic [WIDTH-1:0]  b_i,
`ifdef VEDIC_MULT_SIGNED_EN
  input  logic              signed_i,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] p_o,
  output logic              busy_o
);

  localparam logic [COL_W-1:0] LastCol = COL_W'(PROD_W - 2);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [COL_W-1:0]  col_q, col_d, carry_q, carry_d;
  logic [COL_W-1:0]  col_sum, s;
  logic [PROD_W-1:0] p_q, p_d;
  logic              accept, last;
`ifdef VEDIC_MULT_SIGNED_EN
  logic              neg_q, neg_d;
`endif

  vedic_column_sum #(
    .WIDTH(WIDTH)
  ) u_column_sum (
    .a_i  (a_q),
    .b_i  (b_q),
    .col_i(col_q),
    .sum_o(col_sum)
  );

  assign s    = col_sum + carry_q;
  assign last = (col_q == LastCol);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    col_d    = col_q;
    carry_d  = carry_q;
    p_d      = p_q;
`ifdef VEDIC_MULT_SIGNED_EN
    neg_d    = neg_q;
`endif
    in_ready = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    accept   = in_valid && in_ready;

    unique case (state_q)
      StIdle: if (accept) state_d = StCalc;
      StCalc: begin
        // The last column also owns the top product bit, taken from s[1].
        for (int unsigned n = 0; n < PROD_W; n++) begin
          if (n == 32'(col_q)) p_d[n] = s[0];
          else if (last && (n == 32'(col_q) + 32'd1)) p_d[n] = s[1];
        end
        carry_d = s >> 1;
        col_d   = col_q + 1'b1;
        if (last) begin
          state_d = StDone;
          col_d   = col_q;
`ifdef VEDIC_MULT_SIGNED_EN
          if (neg_q) p_d = -p_d;
`endif
        end
      end
      StDone: if (out_ready) state_d = in_valid ? StCalc : StIdle;
      default: state_d = StIdle;
    endcase

    if (accept) begin
      carry_d = '0;
      p_d     = '0;
      col_d   = '0;
`ifdef VEDIC_MULT_SIGNED_EN
      // Magnitudes only; -2^(WIDTH-1) negates to itself, which is its unsigned magnitude.
      a_d     = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
      b_d     = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
      neg_d   = signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
`else
      a_d     = a_i;
      b_d     = b_i;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      col_q   <= '0;
      carry_q <= '0;
      p_q     <= '0;
`ifdef VEDIC_MULT_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      col_q   <= col_d;
      carry_q <= carry_d;
      p_q     <= p_d;
`ifdef VEDIC_MULT_SIGNED_EN
      neg_q   <= neg_d;
`endif
    end
  end

  assign out_valid = (state_q == StDone);
  assign busy_o    = (state_q == StCalc);
  assign p_o       = p_q;

endmodule

// File: tb/tb_vedic_mult_seq.sv
// Scoreboard bench for vedic_mult_seq at WIDTH=4 and WIDTH=8.
module tb_vedic_mult_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [3:0] a4, b4;
  logic [7:0] p4;
  logic in_valid8, in_ready8, out_valid8, busy8;
  logic out_ready8;
  logic [7:0] a8, b8;
  logic [15:0] p8;
`ifdef VEDIC_MULT_SIGNED_EN
  logic sgn;
`endif

  vedic_mult_seq #(.WIDTH(4)) u_dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid4),
    .in_ready (in_ready4),
    .a_i      (a4),
    .b_i      (b4),
`ifdef VEDIC_MULT_SIGNED_EN
    .signed_i (sgn),
`endif
    .out_valid(out_valid4),
    .out_ready(out_ready4),
    .p_o      (p4),
    .busy_o   (busy4)
  );

  vedic_mult_seq #(.WIDTH(8)) u_dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid8),
    .in_ready (in_ready8),
    .a_i      (a8),
    .b_i      (b8),
`ifdef VEDIC_MULT_SIGNED_EN
    .signed_i (1'b0),
`endif
    .out_valid(out_valid8),
    .out_ready(out_ready8),
    .p_o      (p8),
    .busy_o   (busy8)
  );

  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned hs_cyc4 = 0;
  int unsigned busy_cnt4 = 0;
  logic seen4 = 1'b0;
  logic seen8 = 1'b0;
  logic [7:0]  exp_q4[$];
  int unsigned acc_q4[$];
  logic [15:0] exp_q8[$];
  int unsigned acc_q8[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
  endtask

  // Present operands, wait for acceptance, then queue the expected product.
  task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp,
                        input bit hold, input bit chk_b2b);
    bit ok = 0;
    @(negedge clk);
    a4 = a;
    b4 = b;
    in_valid4 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (in_ready4) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("accept_timeout4", {31'b0, in_ready4}, 32'd1);
    #1;
    exp_q4.push_back(exp);
    acc_q4.push_back(cyc);
    if (chk_b2b) check("b2b_accept_cycle", cyc, hs_cyc4 + 1);
    if (!hold) in_valid4 = 1'b0;
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
    bit ok = 0;
    @(negedge clk);
    a8 = a;
    b8 = b;
    in_valid8 = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      if (in_ready8) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("accept_timeout8", {31'b0, in_ready8}, 32'd1);
    #1;
    exp_q8.push_back(exp);
    acc_q8.push_back(cyc);
    in_valid8 = 1'b0;
  endtask

  task automatic wait_valid4();
    for (int i = 0; i < 40 && !out_valid4; i++) @(negedge clk);
    check("valid_timeout4", {31'b0, out_valid4}, 32'd1);
  endtask

  // Monitor for the 4-bit instance: latency, busy span, stall stability, product.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen4 = 1'b0;
      busy_cnt4 = 0;
    end else begin
      if (busy4) busy_cnt4++;
      if (out_valid4 && !seen4) begin
        seen4 = 1'b1;
        if (acc_q4.size() == 0) check("unexpected_valid4", {31'b0, out_valid4}, 32'd0);
        else check("latency4", cyc - acc_q4[0], 32'd7);
        check("busy_cycles4", busy_cnt4, 32'd7);
        busy_cnt4 = 0;
      end
      if (out_valid4 && !out_ready4 && exp_q4.size() != 0) begin
        check("stall_p_stable", {24'b0, p4}, {24'b0, exp_q4[0]});
        check("stall_in_ready", {31'b0, in_ready4}, 32'd0);
      end
      if (out_valid4 && out_ready4) begin
        if (exp_q4.size() == 0) begin
          check("unexpected_output4", {31'b0, out_valid4}, 32'd0);
        end else begin
          check("product4", {24'b0, p4}, {24'b0, exp_q4.pop_front()});
          void'(acc_q4.pop_front());
        end
        seen4 = 1'b0;
        hs_cyc4 = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      seen8 = 1'b0;
    end else begin
      if (out_valid8 && !seen8) begin
        seen8 = 1'b1;
        if (acc_q8.size() == 0) check("unexpected_valid8", {31'b0, out_valid8}, 32'd0);
        else check("latency8", cyc - acc_q8[0], 32'd15);
      end
      if (out_valid8 && out_ready8) begin
        if (exp_q8.size() == 0) begin
          check("unexpected_output8", {31'b0, out_valid8}, 32'd0);
        end else begin
          check("product8", {16'b0, p8}, {16'b0, exp_q8.pop_front()});
          void'(acc_q8.pop_front());
        end
        seen8 = 1'b0;
      end
    end
  end

  initial begin
    logic [7:0] ra, rb;
    rst_n = 1'b0;
    in_valid4 = 1'b0;
    in_valid8 = 1'b0;
    out_ready4 = 1'b1;
    out_ready8 = 1'b1;
    a4 = '0;
    b4 = '0;
    a8 = '0;
    b8 = '0;
`ifdef VEDIC_MULT_SIGNED_EN
    sgn = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid4}, 32'd0);
    check("rst_busy", {31'b0, busy4}, 32'd0);
    check("rst_p", {24'b0, p4}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready4}, 32'd1);
    rst_n = 1'b1;

    issue4(4'd15, 4'd15, 8'hE1, 1'b0, 1'b0);
    wait_valid4();

    // Stall the consumer for several cycles on each of two products.
    @(posedge clk);
    #1 out_ready4 = 1'b0;
    issue4(4'd0, 4'd13, 8'd0, 1'b0, 1'b0);
    wait_valid4();
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 out_ready4 = 1'b1;
    @(posedge clk);
    #1 out_ready4 = 1'b0;
    issue4(4'd1, 4'd9, 8'd9, 1'b0, 1'b0);
    wait_valid4();
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 out_ready4 = 1'b1;

    issue4(4'd7, 4'd6, 8'd42, 1'b1, 1'b0);
    issue4(4'd11, 4'd3, 8'd33, 1'b0, 1'b1);
    wait_valid4();
    repeat (2) @(negedge clk);

    // Reset while column 3 is being computed.
    issue4(4'd9, 4'd9, 8'd81, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q4.delete();
    acc_q4.delete();
    @(negedge clk);
    check("midrst_p", {24'b0, p4}, 32'd0);
    check("midrst_busy", {31'b0, busy4}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("midrst_no_valid", {31'b0, out_valid4}, 32'd0);
    end
    issue4(4'd5, 4'd5, 8'd25, 1'b0, 1'b0);
    wait_valid4();

`ifdef VEDIC_MULT_SIGNED_EN
    sgn = 1'b1;
    issue4(4'b1000, 4'd7, 8'hC8, 1'b0, 1'b0);
    issue4(4'b1000, 4'b1000, 8'h40, 1'b0, 1'b0);
    sgn = 1'b0;
    issue4(4'd8, 4'd7, 8'd56, 1'b0, 1'b0);
`endif

    issue8(8'd255, 8'd255, 16'hFE01);
    issue8(8'd128, 8'd2, 16'd256);
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      issue8(ra, rb, {8'b0, ra} * {8'b0, rb});
    end

    for (int i = 0; i < 100 && (exp_q4.size() != 0 || exp_q8.size() != 0); i++) @(negedge clk);
    check("drain_q4", exp_q4.size(), 32'd0);
    check("drain_q8", exp_q8.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
